// File: rtl/sa_feeder_pkg.sv
// Shared types for the systolic-array feeder: lane width, PE mux encoding, feeder states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: NUM_BITS, mux_e (PASS/LATCH/COMPUTE/HOLD), state_e, saturating 32-bit increment helper.
package sa_feeder_pkg;

    localparam int NUM_BITS = 8;

    // Broadcast PE mux control; the encoding is fixed by the PE array.
    typedef enum logic [1:0] {
        PASS    = 2'd0,
        LATCH   = 2'd1,
        COMPUTE = 2'd2,
        HOLD    = 2'd3
    } mux_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLOAD  = 3'd1,
        WSHIFT = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sa_feeder_if.sv
// Bundle of every non-clock/reset signal between the feeder and its environment.
// Latency: n/a (wires only).
// Backpressure: carries the w_valid/w_ready and a_valid/a_ready handshakes.
// Modports: master = job/data source (drives start, weights, activations); slave = the feeder.
interface sa_feeder_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int NB = sa_feeder_pkg::NUM_BITS;

    logic                 start_i;
    logic                 reuse_w_i;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic [COLS*NB-1:0]   w_data_i;
    logic                 a_valid_i;
    logic                 a_ready_o;
    logic [ROWS*NB-1:0]   a_data_i;
    logic                 a_last_i;
    logic [COLS*NB-1:0]   top_o;
    logic [ROWS*NB-1:0]   left_o;
    logic [1:0]           mux_o;
    logic [ROWS-1:0]      add_zero_o;
    logic                 busy_o;
    logic                 done_o;
    logic [31:0]          stream_cyc_o;
    logic [31:0]          bubble_cyc_o;

    modport master (
        output start_i, reuse_w_i,
        output w_valid_i, w_data_i,
        output a_valid_i, a_data_i, a_last_i,
        input  w_ready_o, a_ready_o,
        input  top_o, left_o, mux_o, add_zero_o,
        input  busy_o, done_o, stream_cyc_o, bubble_cyc_o
    );

    modport slave (
        input  start_i, reuse_w_i,
        input  w_valid_i, w_data_i,
        input  a_valid_i, a_data_i, a_last_i,
        output w_ready_o, a_ready_o,
        output top_o, left_o, mux_o, add_zero_o,
        output busy_o, done_o, stream_cyc_o, bubble_cyc_o
    );

endinterface

// File: rtl/sa_feeder_skew_line.sv
// Per-row activation delay line: DEPTH registers of one lane, zero on reset; DEPTH=0 is a plain wire.
// Latency: DEPTH cycles.
// Backpressure: none; shifts every cycle.
// Ports: clk, rst_n (sync, active-low), din (lane in), dout (lane out).
module skew_line
    import sa_feeder_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] din,
    output logic [NUM_BITS-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        // Clock and reset are not needed for a zero-depth line.
        logic unused_ok;
        assign unused_ok = clk ^ rst_n;
        assign dout      = din;
    end else begin : g_chain
        logic [DEPTH-1:0][NUM_BITS-1:0] stage;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stage <= '0;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/sa_feeder.sv
// Feeder/sequencer for a ROWS x COLS weight-stationary array: loads a weight tile, shifts it down, streams skewed activations, drains.
// Latency: outputs registered; vector accepted at t is on left_o row r at t+1+r; done_o 1+2*ROWS+N+ROWS+COLS-1 cycles after start (no stalls).
// Backpressure: readies are state decodes; the array never stalls, a missing activation becomes a zero bubble.
// Ports: clk_i, rst_ni (sync, active-low); bus (sa_feeder_if.slave) = job control, weight/activation handshakes, array drive, status, perf counters.
// Build option: SA_FEEDER_PERF_EN adds saturating STREAM-cycle and bubble-cycle counters; without it both counter ports are constant 0.
module sa_feeder
    import sa_feeder_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    sa_feeder_if.slave bus
);

    localparam int W_W    = COLS * NUM_BITS;
    localparam int A_W    = ROWS * NUM_BITS;
    localparam int CNT_W  = $clog2(ROWS + COLS) + 1;
    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(ROWS + COLS - 2);

    state_e            state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;      // beat index in WLOAD, k in WSHIFT, cycle in DRAIN
    logic              w_acc, a_acc;
    logic [W_W-1:0]    wbuf [ROWS];
    logic [W_W-1:0]    top_q, top_nxt;
    mux_e              mux_q, mux_nxt;
    logic              done_q, done_nxt;
    logic [A_W-1:0]    stage0_q;
    logic [A_W-1:0]    left;
    logic [RIDX_W-1:0] shift_idx;
    logic              compute_ph;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        w_acc     = 1'b0;
        a_acc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    cnt_nxt   = '0;
                    state_nxt = bus.reuse_w_i ? STREAM : WLOAD;
                end
            end
            WLOAD: begin
                if (bus.w_valid_i) begin
                    w_acc = 1'b1;
                    if (cnt_q == LAST_ROW) begin
                        state_nxt = WSHIFT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            WSHIFT: begin
                if (cnt_q == LAST_ROW) begin
                    state_nxt = STREAM;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (bus.a_valid_i) begin
                    a_acc = 1'b1;
                    if (bus.a_last_i) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_END) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- registered array drive ----------------
    // top_o/mux_o are computed from the *next* state so both flops switch on
    // the same edge as the state they belong to.
    assign shift_idx = RIDX_W'(LAST_ROW - cnt_nxt);

    always_comb begin
        mux_nxt  = HOLD;
        top_nxt  = '0;
        done_nxt = (state_q == DRAIN) && (state_nxt == IDLE);
        case (state_nxt)
            WSHIFT: begin
                mux_nxt = (cnt_nxt == LAST_ROW) ? LATCH : PASS;
                // Entering k=0 the last weight row is still on the bus, not yet in wbuf.
                top_nxt = (state_q == WLOAD) ? bus.w_data_i : wbuf[shift_idx];
            end
            STREAM, DRAIN: mux_nxt = COMPUTE;
            default: mux_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mux_q    <= HOLD;
            top_q    <= '0;
            done_q   <= 1'b0;
            stage0_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
                wbuf[r] <= '0;
            end
        end else begin
            mux_q  <= mux_nxt;
            top_q  <= top_nxt;
            done_q <= done_nxt;
            // Non-accepting cycles (bubbles, drain, idle) inject zeros.
            stage0_q <= a_acc ? bus.a_data_i : '0;
            if (w_acc) begin
                wbuf[RIDX_W'(cnt_q)] <= bus.w_data_i;
            end
        end
    end

    // ---------------- diagonal skew ----------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_line #(
            .DEPTH (r)
        ) u_skew (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .din   (stage0_q[r*NUM_BITS +: NUM_BITS]),
            .dout  (left[r*NUM_BITS +: NUM_BITS])
        );
    end

    // ---------------- status / outputs ----------------
    assign compute_ph     = (state_q == STREAM) || (state_q == DRAIN);
    assign bus.w_ready_o  = (state_q == WLOAD);
    assign bus.a_ready_o  = (state_q == STREAM);
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.done_o     = done_q;
    assign bus.mux_o      = mux_q;
    assign bus.top_o      = top_q;
    assign bus.left_o     = left;
    // Only row 0 starts a fresh partial sum; lower rows accumulate from above.
    assign bus.add_zero_o = ROWS'(compute_ph);

`ifdef SA_FEEDER_PERF_EN
    logic [31:0] stream_cyc_q, bubble_cyc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stream_cyc_q <= '0;
            bubble_cyc_q <= '0;
        end else if ((state_q == IDLE) && bus.start_i) begin
            stream_cyc_q <= '0;
            bubble_cyc_q <= '0;
        end else if (state_q == STREAM) begin
            stream_cyc_q <= sat_inc(stream_cyc_q);
            if (!a_acc) begin
                bubble_cyc_q <= sat_inc(bubble_cyc_q);
            end
        end
    end

    assign bus.stream_cyc_o = stream_cyc_q;
    assign bus.bubble_cyc_o = bubble_cyc_q;
`else
    assign bus.stream_cyc_o = '0;
    assign bus.bubble_cyc_o = '0;
`endif

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder (ROWS=3, COLS=2) against a per-cycle expectation table built from the job rules.
// Latency: n/a.
// Backpressure: bench drives random valid gaps, out-of-phase noise and stray start pulses.
module tb_sa_feeder;

    localparam int R    = 3;
    localparam int C    = 2;
    localparam int NB   = 8;
    localparam int WW   = C * NB;
    localparam int AW   = R * NB;
    localparam int MAXC = 128;
    localparam int MAXV = 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    sa_feeder_if #(.ROWS(R), .COLS(C)) bus ();

    sa_feeder #(.ROWS(R), .COLS(C)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string tname;

    // job description
    logic [WW-1:0] wts  [R];
    logic [AW-1:0] vecs [MAXV];

    // expectation / drive tables, one entry per cycle from the start cycle
    int            len, wshift0_idx, exp_sc, exp_bc;
    logic [1:0]    e_mux  [MAXC];
    logic [WW-1:0] e_top  [MAXC];
    bit            e_wr [MAXC], e_ar [MAXC], e_busy [MAXC], e_done [MAXC], e_az [MAXC];
    logic [AW-1:0] acc    [MAXC];
    bit            d_start [MAXC], d_reuse [MAXC], d_wv [MAXC], d_av [MAXC], d_last [MAXC];
    logic [WW-1:0] d_wd   [MAXC];
    logic [AW-1:0] d_ad   [MAXC];
    logic [WW-1:0] seen_top [R];

    function automatic logic [WW-1:0] rnd_w();
        return WW'($urandom);
    endfunction

    function automatic logic [AW-1:0] rnd_a();
        return AW'($urandom);
    endfunction

    task automatic set_exp(input int i, input logic [1:0] m, input logic [WW-1:0] t,
                           input bit wr, input bit ar, input bit busy, input bit dn, input bit az);
        e_mux[i] = m;  e_top[i] = t;  e_wr[i] = wr;  e_ar[i] = ar;
        e_busy[i] = busy;  e_done[i] = dn;  e_az[i] = az;
    endtask

    task automatic idle_inputs();
        bus.start_i = 0; bus.reuse_w_i = 0; bus.w_valid_i = 0; bus.w_data_i = '0;
        bus.a_valid_i = 0; bus.a_data_i = '0; bus.a_last_i = 0;
    endtask

    // Lays out one job: IDLE start, WLOAD (R beats), WSHIFT (R cycles), STREAM (n vectors),
    // DRAIN (R+C-1 cycles), IDLE with done. Pure table fill, no comparisons.
    task automatic build_job(input bit reuse, input int n, input int wst, input int ast,
                             input int gap_at, input bit noise);
        int i, beats, got, gaps, sc, bc;
        bit v;
        for (int j = 0; j < MAXC; j++) begin
            set_exp(j, 2'd3, '0, 0, 0, 0, 0, 0);
            acc[j] = '0;  d_start[j] = 0;  d_reuse[j] = 0;
            d_wv[j] = noise ? 1'($urandom) : 1'b0;
            d_av[j] = noise ? 1'($urandom) : 1'b0;
            d_last[j] = noise ? 1'($urandom) : 1'b0;
            d_wd[j] = noise ? rnd_w() : '0;
            d_ad[j] = noise ? rnd_a() : '0;
        end
        d_start[0] = 1;  d_reuse[0] = reuse;
        i = 1;
        if (!reuse) begin
            beats = 0;
            while (beats < R) begin
                set_exp(i, 2'd3, '0, 1, 0, 1, 0, 0);
                v = (i > 60) || ($urandom_range(0, 99) >= wst);
                d_wv[i] = v;
                if (v) begin
                    d_wd[i] = wts[beats];
                    beats++;
                end
                i++;
            end
            for (int k = 0; k < R; k++) begin
                if (k == 0) wshift0_idx = i;
                set_exp(i, (k == R-1) ? 2'd1 : 2'd0, wts[R-1-k], 0, 0, 1, 0, 0);
                i++;
            end
        end
        got = 0;  gaps = 0;  sc = 0;  bc = 0;
        while (got < n) begin
            set_exp(i, 2'd2, '0, 0, 1, 1, 0, 1);
            if (got == gap_at && gaps < 2) begin
                v = 0;
                gaps++;
            end else begin
                v = (i > 90) || ($urandom_range(0, 99) >= ast);
            end
            d_av[i] = v;
            if (v) begin
                d_ad[i] = vecs[got];
                d_last[i] = (got == n-1);
                acc[i] = vecs[got];
                got++;
            end else begin
                bc++;
            end
            sc++;
            i++;
        end
        for (int k = 0; k < R+C-1; k++) begin
            set_exp(i, 2'd2, '0, 0, 0, 1, 0, 1);
            i++;
        end
        set_exp(i, 2'd3, '0, 0, 0, 0, 1, 0);
        len = i + 1;
        if (noise) begin
            for (int j = 1; j < len-1; j++) begin
                if ($urandom_range(0, 5) == 0) begin
                    d_start[j] = 1;
                    d_reuse[j] = 1'($urandom);
                end
            end
        end
`ifdef SA_FEEDER_PERF_EN
        exp_sc = sc;  exp_bc = bc;
`else
        exp_sc = 0;   exp_bc = 0;
`endif
    endtask

    // Plays table cycles 0..min(stop,len-1); observes #1 after each edge, then drives that cycle's inputs.
    task automatic play_job(input int stop);
        int k;
        logic [AW-1:0] exp_left;
        logic [R-1:0]  exp_az;
        k = 0;
        for (int i = 0; i < len && i <= stop; i++) begin
            for (int r = 0; r < R; r++) begin
                exp_left[r*NB +: NB] = '0;
                if (i - 1 - r >= 0) exp_left[r*NB +: NB] = acc[i-1-r][r*NB +: NB];
            end
            exp_az = R'(e_az[i]);
            n_checks++;
            if (bus.mux_o !== e_mux[i]) begin
                n_fail++; $display("FAIL %s mux cyc=%0d got=%0d exp=%0d", tname, i, bus.mux_o, e_mux[i]);
            end
            n_checks++;
            if (bus.top_o !== e_top[i]) begin
                n_fail++; $display("FAIL %s top cyc=%0d got=%h exp=%h", tname, i, bus.top_o, e_top[i]);
            end
            n_checks++;
            if (bus.left_o !== exp_left) begin
                n_fail++; $display("FAIL %s left cyc=%0d got=%h exp=%h", tname, i, bus.left_o, exp_left);
            end
            n_checks++;
            if (bus.w_ready_o !== e_wr[i]) begin
                n_fail++; $display("FAIL %s w_ready cyc=%0d got=%b exp=%b", tname, i, bus.w_ready_o, e_wr[i]);
            end
            n_checks++;
            if (bus.a_ready_o !== e_ar[i]) begin
                n_fail++; $display("FAIL %s a_ready cyc=%0d got=%b exp=%b", tname, i, bus.a_ready_o, e_ar[i]);
            end
            n_checks++;
            if (bus.busy_o !== e_busy[i]) begin
                n_fail++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", tname, i, bus.busy_o, e_busy[i]);
            end
            n_checks++;
            if (bus.done_o !== e_done[i]) begin
                n_fail++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tname, i, bus.done_o, e_done[i]);
            end
            n_checks++;
            if (bus.add_zero_o !== exp_az) begin
                n_fail++; $display("FAIL %s add_zero cyc=%0d got=%b exp=%b", tname, i, bus.add_zero_o, exp_az);
            end
            if ((e_mux[i] == 2'd0 || e_mux[i] == 2'd1) && k < R) begin
                seen_top[k] = bus.top_o;
                k++;
            end
            bus.start_i   = d_start[i];  bus.reuse_w_i = d_reuse[i];
            bus.w_valid_i = d_wv[i];     bus.w_data_i  = d_wd[i];
            bus.a_valid_i = d_av[i];     bus.a_data_i  = d_ad[i];  bus.a_last_i = d_last[i];
            @(posedge clk_i); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        tname = "reset";
        rst_ni = 0;
        bus.start_i = 1; bus.reuse_w_i = 0; bus.w_valid_i = 1; bus.w_data_i = rnd_w();
        bus.a_valid_i = 1; bus.a_data_i = rnd_a(); bus.a_last_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++; if (bus.mux_o !== 2'd3) begin n_fail++; $display("FAIL reset mux got=%0d exp=3", bus.mux_o); end
        n_checks++; if (bus.top_o !== '0) begin n_fail++; $display("FAIL reset top got=%h exp=0", bus.top_o); end
        n_checks++; if (bus.left_o !== '0) begin n_fail++; $display("FAIL reset left got=%h exp=0", bus.left_o); end
        n_checks++; if (bus.add_zero_o !== '0) begin n_fail++; $display("FAIL reset add_zero got=%b exp=0", bus.add_zero_o); end
        n_checks++; if ({bus.w_ready_o, bus.a_ready_o, bus.busy_o, bus.done_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset status got=%b exp=0000", {bus.w_ready_o, bus.a_ready_o, bus.busy_o, bus.done_o});
        end
        n_checks++; if ({bus.stream_cyc_o, bus.bubble_cyc_o} !== 64'd0) begin
            n_fail++; $display("FAIL reset counters got=%0d/%0d exp=0/0", bus.stream_cyc_o, bus.bubble_cyc_o);
        end
        idle_inputs();
        rst_ni = 1;
        @(posedge clk_i); #1;
    endtask

    task automatic check_counters();
        n_checks++;
        if (bus.stream_cyc_o !== 32'(exp_sc)) begin
            n_fail++; $display("FAIL %s stream_cyc got=%0d exp=%0d", tname, bus.stream_cyc_o, exp_sc);
        end
        n_checks++;
        if (bus.bubble_cyc_o !== 32'(exp_bc)) begin
            n_fail++; $display("FAIL %s bubble_cyc got=%0d exp=%0d", tname, bus.bubble_cyc_o, exp_bc);
        end
    endtask

    task automatic test_wshift_stream();
        tname = "directed";
        wts[0] = {8'd2, 8'd1};  wts[1] = {8'd4, 8'd3};  wts[2] = {8'd6, 8'd5};
        vecs[0] = {8'd7, 8'd6, 8'd5};  vecs[1] = {8'd10, 8'd9, 8'd8};
        build_job(0, 2, 0, 0, -1, 0);
        play_job(MAXC);
        // The value on top_o at the latch cycle lands in row 0; each earlier shift cycle is one row deeper.
        for (int r = 0; r < R; r++) begin
            n_checks++;
            if (seen_top[R-1-r] !== wts[r]) begin
                n_fail++; $display("FAIL %s stationary row%0d got=%h exp=%h", tname, r, seen_top[R-1-r], wts[r]);
            end
        end
        check_counters();
    endtask

    task automatic test_bubble();
        tname = "bubble";
        for (int r = 0; r < R; r++) wts[r] = rnd_w();
        for (int v = 0; v < 4; v++) vecs[v] = rnd_a();
        build_job(0, 4, 0, 0, 2, 0);
        play_job(MAXC);
        check_counters();
    endtask

    task automatic test_reuse();
        tname = "reuse";
        vecs[0] = {8'd7, 8'd6, 8'd5};  vecs[1] = {8'd10, 8'd9, 8'd8};
        build_job(1, 2, 0, 0, -1, 0);
        play_job(MAXC);
        check_counters();
    endtask

    task automatic test_reset_mid();
        tname = "reset_mid";
        for (int r = 0; r < R; r++) wts[r] = rnd_w();
        for (int v = 0; v < 3; v++) vecs[v] = rnd_a();
        build_job(0, 3, 0, 0, -1, 0);
        play_job(wshift0_idx - 1);
        n_checks++;
        if (bus.mux_o !== 2'd0 || bus.top_o !== wts[R-1]) begin
            n_fail++; $display("FAIL reset_mid wshift0 got=%0d/%h exp=0/%h", bus.mux_o, bus.top_o, wts[R-1]);
        end
        rst_ni = 0;
        @(posedge clk_i); #1;
        rst_ni = 1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (bus.mux_o !== 2'd3 || bus.top_o !== '0 || bus.left_o !== '0 || bus.add_zero_o !== '0) begin
                n_fail++; $display("FAIL reset_mid drive c=%0d got=%0d/%h/%h/%b exp=3/0/0/0", c, bus.mux_o, bus.top_o, bus.left_o, bus.add_zero_o);
            end
            n_checks++;
            if ({bus.w_ready_o, bus.a_ready_o, bus.busy_o, bus.done_o} !== 4'b0) begin
                n_fail++; $display("FAIL reset_mid status c=%0d got=%b exp=0000", c, {bus.w_ready_o, bus.a_ready_o, bus.busy_o, bus.done_o});
            end
            @(posedge clk_i); #1;
        end
        tname = "after_reset";
        for (int r = 0; r < R; r++) wts[r] = rnd_w();
        build_job(0, 3, 20, 20, -1, 1);
        play_job(MAXC);
        check_counters();
    endtask

    task automatic test_start_in_stream();
        tname = "start_in_stream";
        for (int v = 0; v < 3; v++) vecs[v] = rnd_a();
        build_job(1, 3, 0, 0, -1, 0);
        d_start[2] = 1;  d_reuse[2] = 0;   // STREAM
        d_start[5] = 1;  d_reuse[5] = 1;   // DRAIN
        play_job(MAXC);
        check_counters();
    endtask

    task automatic test_random();
        int n, gap;
        bit reuse;
        for (int j = 0; j < 12; j++) begin
            $sformat(tname, "random%0d", j);
            n = $urandom_range(1, MAXV);
            for (int v = 0; v < n; v++) vecs[v] = rnd_a();
            reuse = (j > 0) && ($urandom_range(0, 2) == 0);
            if (!reuse) for (int r = 0; r < R; r++) wts[r] = rnd_w();
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n-1) : -1;
            build_job(reuse, n, 25, 35, gap, 1);
            play_job(MAXC);
            check_counters();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_wshift_stream();
        test_bubble();
        test_reuse();
        test_reset_mid();
        test_start_in_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
